lsu: RTL and testbench
======================

# lsu

Load/store unit for the RISC-V core: the initiator side of the data-memory interface. Accepts one load or store per transaction from the execute stage, converts the byte address and RV32I width code (funct3) into a word address, byte-enable mask and lane-aligned write data, and drives the word-addressed data memory with a request/grant/rvalid handshake. It extracts and sign- or zero-extends load data, and returns a response with an error flag and RVFI-style read/write masks.

## Interface
- MEMSIZE, 64, memory depth in 32-bit words; word-address width AW = $clog2(MEMSIZE)
- clk  in  1  clock; all state changes on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request from pipeline
- req_ready  out  1  LSU can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  width code: loads 0/1/2/4/5 (LB/LH/LW/LBU/LHU); stores 0/1/2 (SB/SH/SW)
- req_addr  in  32  byte address
- req_wdata  in  32  store value, right-justified
- resp_valid  out  1  response available
- resp_ready  in  1  pipeline consumes response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, out-of-range or illegal funct3
- resp_rmask / resp_wmask  out  4  byte lanes read / written; 0 on error
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepts request this cycle
- mem_we  out  1  write request
- mem_addr  out  AW  word index = req_addr[AW+1:2]
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated store data
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  raw word

## Operation
- States: IDLE, ISSUE, WAIT_R, RESP. Reset to IDLE; all outputs 0 except req_ready = 1.
- IDLE: req_ready = 1. On req_valid, register the request and decode it (off = addr[1:0]):
  - Error if any of: funct3 illegal for the direction; halfword with off[0] = 1; word with off != 0; addr[31:AW+2] != 0.
  - On error: go to RESP with resp_err = 1. No memory access.
  - Otherwise: go to ISSUE.
- ISSUE: mem_req = 1, with mem_addr, mem_we, mem_be and mem_wdata held stable until mem_gnt.
  - On mem_gnt, a store goes to RESP with resp_wmask = mem_be; a load goes to WAIT_R.
- Byte enables and write data:
  - Byte: be = 0001 << off; wdata = {4{value[7:0]}}.
  - Half: be = 0011 << off; wdata = {2{value[15:0]}}.
  - Word: be = 1111; wdata = value.
  - Loads drive mem_be with the same lane mask; mem_wdata = 0.
- WAIT_R: mem_rvalid is sampled only in this state. On mem_rvalid:
  - Compute shifted = mem_rdata >> (8*off).
  - LB/LBU sign- or zero-extend shifted[7:0]; LH/LHU extend shifted[15:0]; LW takes the word.
  - resp_rmask = lane mask. Go to RESP.
- RESP: resp_valid = 1 with all resp_* held stable until resp_ready, then return to IDLE. resp_* are cleared to 0 on leaving RESP.
- mem_rvalid outside WAIT_R is ignored. mem_gnt while mem_req = 0 is ignored.

## Timing
- Request accepted in cycle 0. ISSUE is cycle 1, with mem_req registered.
- Store with immediate grant: resp_valid in cycle 2.
- Load with grant in cycle 1 and rvalid in cycle 2: resp_valid in cycle 3.
- Error: resp_valid in cycle 1.
- One transaction outstanding at a time; req_ready = 0 from cycle 1 until the cycle after the resp handshake.
- Grant stall: ISSUE persists with identical mem_* outputs for every cycle mem_gnt = 0.
- resp_ready = 0: RESP holds indefinitely; no new request is accepted.
- rst_n asserted mid-transaction: immediately IDLE, mem_req = 0, resp_valid = 0. A late rvalid arriving after release is ignored.

## Structure
- Package lsu_pkg holds:
  - a funct3 width enum (F3_B = 0, F3_H = 1, F3_W = 2, F3_BU = 4, F3_HU = 5);
  - the state enum;
  - a lane_mask(funct3, off) function shared with memory-side RVFI logic.
- Sub-module lsu_load_align (combinational): mem_rdata, off and funct3 in; extended data out. Instantiated once.

## Test plan
- SW addr 0x10, value 0xDEADBEEF, immediate grant: mem_addr = 4, be = 1111, wdata = 0xDEADBEEF. resp_valid in cycle 2 with wmask = 1111, err = 0.
- SB addr 0x13, value 0x000000A5: be = 1000, wdata = 0xA5A5A5A5. Then LB addr 0x13 with mem_rdata = 0xA5000000: rdata = 0xFFFFFFA5. LBU at the same address: rdata = 0x000000A5, rmask = 1000.
- LH addr 0x22 with rdata = 0x80017FFF: rdata = 0xFFFF8001, rmask = 1100. LHU at the same address: rdata = 0x00008001.
- Errors, each giving resp_err = 1 in cycle 1 with mem_req never asserted:
  - LW at 0x2;
  - SH at 0x1;
  - load with funct3 = 3;
  - SB with funct3 = 4;
  - LW at 0x100 with MEMSIZE = 64.
- Flow control: mem_gnt held 0 for 3 cycles, mem_rvalid delayed 2 cycles, resp_ready low 4 cycles. mem_* and resp_* are stable throughout; req_ready stays 0; one response delivered.
- rst_n pulsed low while in WAIT_R, with rvalid the cycle after release: outputs at reset values. The stale rvalid produces no response. The next LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: RV32I width codes, FSM states and
// the byte-lane mask helper also used by the memory-side RVFI logic.
package lsu_pkg;

   typedef enum logic [2:0] {
      F3_B  = 3'd0,
      F3_H  = 3'd1,
      F3_W  = 3'd2,
      F3_BU = 3'd4,
      F3_HU = 3'd5
   } f3_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ISSUE  = 2'd1,
      S_WAIT_R = 2'd2,
      S_RESP   = 2'd3
   } state_e;

   // Lanes touched by an access of the given width at byte offset off.
   function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
      logic [3:0] mask;
      case (funct3)
         F3_B, F3_BU: mask = 4'b0001 << off;
         F3_H, F3_HU: mask = 4'b0011 << off;
         F3_W:        mask = 4'b1111;
         default:     mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/response and word-addressed data-memory signals of
// the LSU; master is the LSU, slave is the pipeline plus memory around it.
interface lsu_if #(parameter int AW = 6);
   logic          req_valid;
   logic          req_ready;
   logic          req_write;
   logic [2:0]    req_funct3;
   logic [31:0]   req_addr;
   logic [31:0]   req_wdata;
   logic          resp_valid;
   logic          resp_ready;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [3:0]    resp_rmask;
   logic [3:0]    resp_wmask;
   logic          mem_req;
   logic          mem_gnt;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;
   logic          mem_rvalid;
   logic [31:0]   mem_rdata;

   modport master (
      input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
             mem_gnt, mem_rvalid, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_err, resp_rmask, resp_wmask,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport slave (
      output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
             mem_gnt, mem_rvalid, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, resp_rmask, resp_wmask,
             mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/lsu_load_align.sv
// Moves the addressed lanes of a raw memory word down to bit 0 and applies
// the sign or zero extension selected by the load width code.
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [31:0] shifted_s;

   always_comb begin
      shifted_s = rdata_i >> {off_i, 3'b000};
      case (funct3_i)
         F3_B:    data_o = {{24{shifted_s[7]}}, shifted_s[7:0]};
         F3_BU:   data_o = {24'h000000, shifted_s[7:0]};
         F3_H:    data_o = {{16{shifted_s[15]}}, shifted_s[15:0]};
         F3_HU:   data_o = {16'h0000, shifted_s[15:0]};
         F3_W:    data_o = shifted_s;
         default: data_o = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Load/store unit: decodes one pipeline access at a time, runs the memory
// request/grant/rvalid handshake and returns an extended, masked response.
module lsu
   import lsu_pkg::*;
#(
   parameter int MEMSIZE = 64
)(
   input  logic   clk,
   input  logic   rst_n,
   lsu_if.master  bus
);

   localparam int AW = $clog2(MEMSIZE);

   state_e        state_q, state_d;
   logic          write_q, write_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [1:0]    off_q, off_d;
   logic          req_ready_q, req_ready_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          resp_valid_q, resp_valid_d;
   logic [31:0]   resp_rdata_q, resp_rdata_d;
   logic          resp_err_q, resp_err_d;
   logic [3:0]    resp_rmask_q, resp_rmask_d;
   logic [3:0]    resp_wmask_q, resp_wmask_d;

   logic [1:0]    in_off_s;
   logic [3:0]    in_be_s;
   logic [31:0]   in_wdata_s;
   logic          f3_ok_s, align_ok_s, range_ok_s, in_err_s;
   logic [31:0]   ld_data_s;

   lsu_load_align u_load_align (
      .rdata_i  (bus.mem_rdata),
      .off_i    (off_q),
      .funct3_i (funct3_q),
      .data_o   (ld_data_s)
   );

   // Decode of the incoming request: legality, lanes and replicated store data.
   always_comb begin
      in_off_s = bus.req_addr[1:0];
      in_be_s  = lane_mask(bus.req_funct3, in_off_s);
      case (bus.req_funct3)
         F3_B, F3_H, F3_W: f3_ok_s = 1'b1;
         F3_BU, F3_HU:     f3_ok_s = ~bus.req_write;
         default:          f3_ok_s = 1'b0;
      endcase
      case (bus.req_funct3)
         F3_H, F3_HU: align_ok_s = ~in_off_s[0];
         F3_W:        align_ok_s = (in_off_s == 2'b00);
         default:     align_ok_s = 1'b1;
      endcase
      range_ok_s = ((bus.req_addr >> (AW + 2)) == 32'd0);
      in_err_s   = ~(f3_ok_s & align_ok_s & range_ok_s);
      if (bus.req_write) begin
         case (bus.req_funct3)
            F3_B:    in_wdata_s = {4{bus.req_wdata[7:0]}};
            F3_H:    in_wdata_s = {2{bus.req_wdata[15:0]}};
            F3_W:    in_wdata_s = bus.req_wdata;
            default: in_wdata_s = 32'h0000_0000;
         endcase
      end else begin
         in_wdata_s = 32'h0000_0000;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) state_d = in_err_s ? S_RESP : S_ISSUE;
            else               state_d = S_IDLE;
         end
         S_ISSUE: begin
            if (bus.mem_gnt) state_d = write_q ? S_RESP : S_WAIT_R;
            else             state_d = S_ISSUE;
         end
         S_WAIT_R: begin
            if (bus.mem_rvalid) state_d = S_RESP;
            else                state_d = S_WAIT_R;
         end
         S_RESP: begin
            if (bus.resp_ready) state_d = S_IDLE;
            else                state_d = S_RESP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; all held unless the state acts on them.
   always_comb begin
      write_d      = write_q;
      funct3_d     = funct3_q;
      off_d        = off_q;
      req_ready_d  = req_ready_q;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_be_d     = mem_be_q;
      mem_wdata_d  = mem_wdata_q;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      resp_rmask_d = resp_rmask_q;
      resp_wmask_d = resp_wmask_q;
      case (state_q)
         S_IDLE: begin
            if (bus.req_valid) begin
               write_d     = bus.req_write;
               funct3_d    = bus.req_funct3;
               off_d       = in_off_s;
               req_ready_d = 1'b0;
               if (in_err_s) begin
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  mem_req_d   = 1'b1;
                  mem_we_d    = bus.req_write;
                  mem_addr_d  = bus.req_addr[AW+1:2];
                  mem_be_d    = in_be_s;
                  mem_wdata_d = in_wdata_s;
               end
            end else begin
               req_ready_d = 1'b1;
            end
         end
         S_ISSUE: begin
            if (bus.mem_gnt) begin
               mem_req_d   = 1'b0;
               mem_we_d    = 1'b0;
               mem_addr_d  = {AW{1'b0}};
               mem_be_d    = 4'b0000;
               mem_wdata_d = 32'h0000_0000;
               if (write_q) begin
                  resp_valid_d = 1'b1;
                  resp_wmask_d = mem_be_q;
               end else begin
                  resp_valid_d = 1'b0;
               end
            end else begin
               mem_req_d = 1'b1;
            end
         end
         S_WAIT_R: begin
            if (bus.mem_rvalid) begin
               resp_valid_d = 1'b1;
               resp_rdata_d = ld_data_s;
               resp_rmask_d = lane_mask(funct3_q, off_q);
            end else begin
               resp_valid_d = 1'b0;
            end
         end
         S_RESP: begin
            if (bus.resp_ready) begin
               resp_valid_d = 1'b0;
               resp_rdata_d = 32'h0000_0000;
               resp_err_d   = 1'b0;
               resp_rmask_d = 4'b0000;
               resp_wmask_d = 4'b0000;
               req_ready_d  = 1'b1;
            end else begin
               resp_valid_d = 1'b1;
            end
         end
         default: begin
            req_ready_d  = 1'b1;
            mem_req_d    = 1'b0;
            resp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q      <= 1'b0;
         funct3_q     <= 3'd0;
         off_q        <= 2'd0;
         req_ready_q  <= 1'b1;
         mem_req_q    <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= {AW{1'b0}};
         mem_be_q     <= 4'b0000;
         mem_wdata_q  <= 32'h0000_0000;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 32'h0000_0000;
         resp_err_q   <= 1'b0;
         resp_rmask_q <= 4'b0000;
         resp_wmask_q <= 4'b0000;
      end else begin
         write_q      <= write_d;
         funct3_q     <= funct3_d;
         off_q        <= off_d;
         req_ready_q  <= req_ready_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_be_q     <= mem_be_d;
         mem_wdata_q  <= mem_wdata_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         resp_rmask_q <= resp_rmask_d;
         resp_wmask_q <= resp_wmask_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_rmask = resp_rmask_q;
   assign bus.resp_wmask = resp_wmask_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed and random accesses against a byte-addressed
// reference memory, with a word-addressed memory device answering the DUT.
module tb_lsu;

   localparam int MEMSIZE = 64;
   localparam int AW      = 6;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   lsu_if #(.AW(AW)) bus ();
   lsu #(.MEMSIZE(MEMSIZE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] dev_mem   [MEMSIZE];
   logic [7:0]  ref_bytes [4*MEMSIZE];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   function automatic int acc_size(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   // One complete transaction: gd grant stall cycles, rd rvalid delay, pd resp_ready delay.
   task automatic do_txn(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input int gd, input int rd, input int pd);
      int          size;
      bit          legal, err;
      logic [3:0]  be;
      logic [31:0] exp_wd, exp_rd;
      logic [AW-1:0] got_addr, wi;
      logic [31:0] got_wd;
      logic [3:0]  got_be;
      logic [7:0]  bidx;
      longint      val;

      size  = acc_size(f3);
      legal = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err   = !legal || ((addr % size) != 0) || (addr >= 32'(4*MEMSIZE));
      be    = err ? 4'h0 : 4'(((1 << size) - 1) << addr[1:0]);
      wi    = addr[AW+1:2];
      if (!wr)            exp_wd = 32'h0;
      else if (size == 1) exp_wd = {24'h0, wd[7:0]} * 32'h0101_0101;
      else if (size == 2) exp_wd = {16'h0, wd[15:0]} * 32'h0001_0001;
      else                exp_wd = wd;
      val = 0;
      for (int i = 0; i < size; i++) begin
         bidx = addr[7:0] + 8'(i);
         val  = val | (longint'(ref_bytes[bidx]) << (8*i));
      end
      if (!f3[2] && val[8*size-1]) val = val - (longint'(1) << (8*size));
      exp_rd = val[31:0];

      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wd;
      sample();
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      step();
      bus.req_valid  = 1'($urandom);
      bus.req_write  = 1'($urandom);
      bus.req_funct3 = 3'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      got_addr = '0;
      got_wd   = 32'h0;
      got_be   = 4'h0;

      if (!err) begin
         for (int g = 0; g <= gd; g++) begin
            bus.mem_gnt    = (g == gd);
            bus.mem_rvalid = 1'($urandom);
            bus.mem_rdata  = $urandom;
            sample();
            chk("issue_mem_req", 32'(bus.mem_req), 32'd1);
            chk("issue_mem_we", 32'(bus.mem_we), 32'(wr));
            chk("issue_mem_addr", 32'(bus.mem_addr), 32'(wi));
            chk("issue_mem_be", 32'(bus.mem_be), 32'(be));
            chk("issue_mem_wdata", bus.mem_wdata, exp_wd);
            chk("issue_resp_valid", 32'(bus.resp_valid), 32'd0);
            chk("issue_req_ready", 32'(bus.req_ready), 32'd0);
            got_addr = bus.mem_addr;
            got_wd   = bus.mem_wdata;
            got_be   = bus.mem_be;
            step();
         end
         bus.mem_gnt    = 1'b0;
         bus.mem_rvalid = 1'b0;
         if (wr) begin
            for (int i = 0; i < 4; i++)
               if (got_be[i]) dev_mem[got_addr][8*i +: 8] = got_wd[8*i +: 8];
            for (int i = 0; i < size; i++) begin
               bidx = addr[7:0] + 8'(i);
               ref_bytes[bidx] = wd[8*i +: 8];
            end
         end else begin
            for (int r = 0; r <= rd; r++) begin
               bus.mem_rvalid = (r == rd);
               bus.mem_rdata  = (r == rd) ? dev_mem[got_addr] : $urandom;
               bus.mem_gnt    = 1'($urandom);
               sample();
               chk("waitr_mem_req", 32'(bus.mem_req), 32'd0);
               chk("waitr_resp_valid", 32'(bus.resp_valid), 32'd0);
               step();
            end
            bus.mem_rvalid = 1'b0;
            bus.mem_gnt    = 1'b0;
         end
      end

      for (int p = 0; p <= pd; p++) begin
         bus.resp_ready = (p == pd);
         bus.mem_rvalid = 1'($urandom);
         bus.mem_gnt    = 1'($urandom);
         bus.mem_rdata  = $urandom;
         sample();
         chk("resp_valid", 32'(bus.resp_valid), 32'd1);
         chk("resp_err", 32'(bus.resp_err), 32'(err));
         chk("resp_rdata", bus.resp_rdata, (err || wr) ? 32'h0 : exp_rd);
         chk("resp_rmask", 32'(bus.resp_rmask), (err || wr) ? 32'h0 : 32'(be));
         chk("resp_wmask", 32'(bus.resp_wmask), (err || !wr) ? 32'h0 : 32'(be));
         chk("resp_mem_req", 32'(bus.mem_req), 32'd0);
         chk("resp_req_ready", 32'(bus.req_ready), 32'd0);
         step();
      end
      bus.resp_ready = 1'b0;
      bus.req_valid  = 1'b0;
      bus.mem_rvalid = 1'b0;
      bus.mem_gnt    = 1'b0;
      sample();
      chk("post_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("post_req_ready", 32'(bus.req_ready), 32'd1);
      chk("post_masks", {24'h0, bus.resp_rmask, bus.resp_wmask}, 32'h0);
      chk("post_rdata_err", bus.resp_rdata | 32'(bus.resp_err), 32'h0);
      step();
   endtask

   initial begin
      int          size;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;

      for (int i = 0; i < MEMSIZE; i++)   dev_mem[i] = 32'h0;
      for (int i = 0; i < 4*MEMSIZE; i++) ref_bytes[i] = 8'h00;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;  bus.req_write = 1'b0;  bus.req_funct3 = 3'd0;
      bus.req_addr  = 32'h0; bus.req_wdata = 32'h0; bus.resp_ready = 1'b0;
      bus.mem_gnt   = 1'b0;  bus.mem_rvalid = 1'b0; bus.mem_rdata  = 32'h0;
      step();
      sample();
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_mem_bus", bus.mem_wdata | {24'h0, bus.mem_be, 3'b0, bus.mem_we}, 32'h0);
      step();
      rst_n = 1'b1;
      step();

      do_txn(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, 0, 0);
      do_txn(1'b1, 3'd0, 32'h13, 32'h0000_00A5, 0, 0, 0);
      do_txn(1'b0, 3'd0, 32'h13, 32'h0, 0, 0, 0);
      do_txn(1'b0, 3'd4, 32'h13, 32'h0, 0, 0, 0);
      do_txn(1'b1, 3'd2, 32'h20, 32'h8001_7FFF, 0, 0, 0);
      do_txn(1'b0, 3'd1, 32'h22, 32'h0, 0, 0, 0);
      do_txn(1'b0, 3'd5, 32'h22, 32'h0, 0, 0, 0);
      do_txn(1'b0, 3'd2, 32'h02, 32'h0, 0, 0, 0);
      do_txn(1'b1, 3'd1, 32'h01, 32'h1234, 0, 0, 0);
      do_txn(1'b0, 3'd3, 32'h00, 32'h0, 0, 0, 0);
      do_txn(1'b1, 3'd4, 32'h00, 32'h55, 0, 0, 0);
      do_txn(1'b0, 3'd2, 32'h100, 32'h0, 0, 0, 0);
      do_txn(1'b0, 3'd2, 32'h10, 32'h0, 3, 2, 4);
      do_txn(1'b1, 3'd1, 32'h2A, 32'hCAFE_9876, 3, 0, 4);

      // Reset while a granted load waits for data; the late rvalid must be dropped.
      bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h20;
      step();
      bus.req_valid = 1'b0;
      bus.mem_gnt   = 1'b1;
      sample();
      chk("rst_mid_issue", 32'(bus.mem_req), 32'd1);
      step();
      bus.mem_gnt = 1'b0;
      rst_n       = 1'b0;
      sample();
      chk("rst_mid_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
      chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
      step();
      rst_n = 1'b1;
      step();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1234_5678;
      sample();
      chk("stale_rv_resp_valid", 32'(bus.resp_valid), 32'd0);
      step();
      bus.mem_rvalid = 1'b0;
      sample();
      chk("stale_rv_after", 32'(bus.resp_valid), 32'd0);
      chk("stale_rv_req_ready", 32'(bus.req_ready), 32'd1);
      step();
      do_txn(1'b0, 3'd2, 32'h20, 32'h0, 0, 0, 0);

      for (int n = 0; n < 250; n++) begin
         wr   = 1'($urandom);
         f3   = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'($urandom_range(0, 2)) | (wr ? 3'd0 : 3'(4 * $urandom_range(0, 1)));
         size = acc_size(f3);
         if ($urandom_range(0, 9) == 0) addr = $urandom;
         else                           addr = 32'($urandom_range(0, 4*MEMSIZE - 1));
         if ($urandom_range(0, 3) != 0) addr = addr & ~32'(size - 1);
         do_txn(wr, f3, addr, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
